// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolution controller.
package br_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP     = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/brcomp.sv
// Operand comparator: equality plus signed or unsigned less-than.
module brcomp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            br_unsigned,
    output logic            br_less,
    output logic            br_equal
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s      = a;
    assign b_s      = b;
    assign br_equal = (a == b);
    assign br_less  = br_unsigned ? (a < b) : (a_s < b_s);

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution: capture, compare, resolve, then hold the
// result for fetch; keeps saturating completion statistics.
module branch_ctrl
    import br_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              CNT_W    = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic             req_jal,
    input  logic             req_jalr,
    input  logic             req_pred,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic [XLEN-1:0]  res_link,
    output logic             res_mispred,
    output logic             res_illegal,
    output logic             res_misalign,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              taken_q, taken_d, mispred_q, mispred_d;
    logic              illegal_q, illegal_d, misalign_q, misalign_d;
    logic [XLEN-1:0]   target_q, target_d, link_q, link_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d, cnt_taken_q, cnt_taken_d;

    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]        f3_q, f3_d;
    logic              jal_q, jal_d, jalr_q, jalr_d, pred_q, pred_d;
    logic              less_q, less_d, equal_q, equal_d;

    logic              br_less, br_equal;
    logic              calc_taken, calc_illegal;
    logic [XLEN-1:0]   calc_target, calc_link, jump_target, jalr_sum;
    logic              unused_bits;

    assign unused_bits = ^RESET_PC;

    brcomp #(.XLEN(XLEN)) u_brcomp (
        .a           (rs1_q),
        .b           (rs2_q),
        .br_unsigned (f3_q[1]),
        .br_less     (br_less),
        .br_equal    (br_equal)
    );

    // JALR wins over JAL; conditional decode only applies when neither is set.
    always_comb begin
        calc_taken   = 1'b0;
        calc_illegal = 1'b0;
        jalr_sum     = rs1_q + imm_q;
        jump_target  = pc_q + imm_q;
        if (jalr_q) begin
            calc_taken  = 1'b1;
            jump_target = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jal_q) begin
            calc_taken = 1'b1;
        end else begin
            case (f3_q)
                F3_BEQ:            calc_taken = equal_q;
                F3_BNE:            calc_taken = ~equal_q;
                F3_BLT, F3_BLTU:   calc_taken = less_q;
                F3_BGE, F3_BGEU:   calc_taken = ~less_q;
                default:           calc_illegal = 1'b1;
            endcase
        end
        calc_link   = pc_q + XLEN'(4);
        calc_target = calc_taken ? jump_target : calc_link;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        res_valid_d  = res_valid_q;
        taken_d      = taken_q;
        target_d     = target_q;
        link_d       = link_q;
        mispred_d    = mispred_q;
        illegal_d    = illegal_q;
        misalign_d   = misalign_q;
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        f3_d         = f3_q;
        jal_d        = jal_q;
        jalr_d       = jalr_q;
        pred_d       = pred_q;
        less_d       = less_q;
        equal_d      = equal_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pc_d        = req_pc;
                    imm_d       = req_imm;
                    rs1_d       = req_rs1;
                    rs2_d       = req_rs2;
                    f3_d        = req_funct3;
                    jal_d       = req_jal;
                    jalr_d      = req_jalr;
                    pred_d      = req_pred;
                    req_ready_d = 1'b0;
                    state_d     = CMP;
                end
            end
            CMP: begin
                less_d  = br_less;
                equal_d = br_equal;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                taken_d     = calc_taken;
                target_d    = calc_target;
                link_d      = calc_link;
                mispred_d   = calc_taken ^ pred_q;
                illegal_d   = calc_illegal;
                misalign_d  = calc_taken & (|calc_target[1:0]);
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    cnt_branch_d = sat_inc(cnt_branch_q);
                    cnt_taken_d  = taken_q ? sat_inc(cnt_taken_q) : cnt_taken_q;
                    res_valid_d  = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides any transition, including a completing handshake.
        if (flush) begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            res_valid_d  = 1'b0;
            cnt_branch_d = cnt_branch_q;
            cnt_taken_d  = cnt_taken_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            res_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            mispred_q    <= 1'b0;
            illegal_q    <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            res_valid_q  <= res_valid_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            link_q       <= link_d;
            mispred_q    <= mispred_d;
            illegal_q    <= illegal_d;
            misalign_q   <= misalign_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        imm_q   <= imm_d;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        f3_q    <= f3_d;
        jal_q   <= jal_d;
        jalr_q  <= jalr_d;
        pred_q  <= pred_d;
        less_q  <= less_d;
        equal_q <= equal_d;
    end

    assign req_ready    = req_ready_q;
    assign res_valid    = res_valid_q;
    assign res_taken    = taken_q;
    assign res_target   = target_q;
    assign res_link     = link_q;
    assign res_mispred  = mispred_q;
    assign res_illegal  = illegal_q;
    assign res_misalign = misalign_q;
    assign cnt_branch   = cnt_branch_q;
    assign cnt_taken    = cnt_taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table plus handshake, flush, reset and
// counter-saturation sequences (a second instance uses 2-bit counters).
module tb_branch_ctrl;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_jal = 1'b0, req_jalr = 1'b0, req_pred = 1'b0;

    logic        req_ready, res_valid, res_taken, res_mispred, res_illegal, res_misalign;
    logic [31:0] res_target, res_link;
    logic [15:0] cnt_branch, cnt_taken;

    logic        unused_rdy, unused_vld, unused_tk, unused_mp, unused_il, unused_ma;
    logic [31:0] unused_tgt, unused_lnk;
    logic [1:0]  d2_cnt_branch, d2_cnt_taken;

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(32), .CNT_W(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_jal(req_jal), .req_jalr(req_jalr), .req_pred(req_pred),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .res_link(res_link), .res_mispred(res_mispred),
        .res_illegal(res_illegal), .res_misalign(res_misalign),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    branch_ctrl #(.XLEN(32), .CNT_W(2), .RESET_PC(32'h0)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(unused_rdy),
        .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_jal(req_jal), .req_jalr(req_jalr), .req_pred(req_pred),
        .res_valid(unused_vld), .res_ready(res_ready), .res_taken(unused_tk),
        .res_target(unused_tgt), .res_link(unused_lnk), .res_mispred(unused_mp),
        .res_illegal(unused_il), .res_misalign(unused_ma),
        .cnt_branch(d2_cnt_branch), .cnt_taken(d2_cnt_taken)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        jal;
        logic        jalr;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mispred;
        logic        illegal;
        logic        misalign;
    } vec_t;

    vec_t vecs[13];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_br = 0;
    int   exp_tk = 0;
    int   lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat2(input int v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    task automatic check_counts(input string tag);
        chk({tag, "_cnt_branch"}, {16'b0, cnt_branch}, 32'(exp_br));
        chk({tag, "_cnt_taken"}, {16'b0, cnt_taken}, 32'(exp_tk));
        chk({tag, "_cnt2_branch"}, {30'b0, d2_cnt_branch}, sat2(exp_br));
        chk({tag, "_cnt2_taken"}, {30'b0, d2_cnt_taken}, sat2(exp_tk));
    endtask

    task automatic drive(input vec_t v);
        req_pc     = v.pc;
        req_imm    = v.imm;
        req_rs1    = v.rs1;
        req_rs2    = v.rs2;
        req_funct3 = v.f3;
        req_jal    = v.jal;
        req_jalr   = v.jalr;
        req_pred   = v.pred;
        req_valid  = 1'b1;
    endtask

    task automatic accept();
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until res_valid, bounded.
    task automatic wait_valid(output int l);
        l = 0;
        while (!res_valid && l < 10) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic complete(input logic tk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_br++;
        if (tk) exp_tk++;
        chk("res_valid_after_hs", {31'b0, res_valid}, 32'd0);
        chk("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
        check_counts("hs");
    endtask

    task automatic check_result(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, "_taken"}, {31'b0, res_taken}, {31'b0, v.taken});
        chk({s, "_target"}, res_target, v.target);
        chk({s, "_link"}, res_link, v.link);
        chk({s, "_mispred"}, {31'b0, res_mispred}, {31'b0, v.mispred});
        chk({s, "_illegal"}, {31'b0, res_illegal}, {31'b0, v.illegal});
        chk({s, "_misalign"}, {31'b0, res_misalign}, {31'b0, v.misalign});
    endtask

    initial begin
        //          f3       jal   jalr  pred  pc            imm           rs1           rs2           tk    target        link          mp    ill   mis
        vecs[0]  = '{F3_BEQ,  1'b0, 1'b0, 1'b0, 32'h100,      32'h20,       32'h1234,     32'h1234,     1'b1, 32'h120,      32'h104,      1'b1, 1'b0, 1'b0};
        vecs[1]  = '{F3_BLT,  1'b0, 1'b0, 1'b1, 32'h200,      32'h10,       32'hFFFFFFFF, 32'h1,        1'b1, 32'h210,      32'h204,      1'b0, 1'b0, 1'b0};
        vecs[2]  = '{F3_BLTU, 1'b0, 1'b0, 1'b1, 32'h200,      32'h10,       32'hFFFFFFFF, 32'h1,        1'b0, 32'h204,      32'h204,      1'b1, 1'b0, 1'b0};
        vecs[3]  = '{F3_BGEU, 1'b0, 1'b0, 1'b0, 32'h200,      32'h10,       32'hFFFFFFFF, 32'h1,        1'b1, 32'h210,      32'h204,      1'b1, 1'b0, 1'b0};
        vecs[4]  = '{F3_BEQ,  1'b0, 1'b1, 1'b1, 32'h40,       32'h4,        32'h2001,     32'h0,        1'b1, 32'h2004,     32'h44,       1'b0, 1'b0, 1'b0};
        vecs[5]  = '{F3_BEQ,  1'b0, 1'b1, 1'b1, 32'h40,       32'h6,        32'h2001,     32'h0,        1'b1, 32'h2006,     32'h44,       1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b010,  1'b0, 1'b0, 1'b0, 32'h300,      32'h8,        32'h0,        32'h0,        1'b0, 32'h304,      32'h304,      1'b0, 1'b1, 1'b0};
        vecs[7]  = '{F3_BNE,  1'b0, 1'b0, 1'b1, 32'h600,      32'h40,       32'h5,        32'h5,        1'b0, 32'h604,      32'h604,      1'b1, 1'b0, 1'b0};
        vecs[8]  = '{F3_BGE,  1'b0, 1'b0, 1'b0, 32'h400,      32'hFFFFFFF0, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h3F0,      32'h404,      1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b010,  1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h8,        32'h0,        32'h0,        1'b1, 32'h4,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{F3_BEQ,  1'b1, 1'b1, 1'b0, 32'h50,       32'h10,       32'h1000,     32'h0,        1'b1, 32'h1010,     32'h54,       1'b1, 1'b0, 1'b0};
        vecs[11] = '{F3_BEQ,  1'b0, 1'b0, 1'b1, 32'h100,      32'h2,        32'h7,        32'h7,        1'b1, 32'h102,      32'h104,      1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b011,  1'b0, 1'b0, 1'b1, 32'h500,      32'h8,        32'h0,        32'h0,        1'b0, 32'h504,      32'h504,      1'b1, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_target", res_target, 32'd0);
        chk("rst_res_taken", {31'b0, res_taken}, 32'd0);
        check_counts("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            accept();
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check_result(vecs[i], i);
            complete(vecs[i].taken);
        end

        // Consumer stall: results and counters must hold while res_ready is low.
        drive(vecs[0]);
        accept();
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_target", res_target, 32'h120);
            chk("stall_taken", {31'b0, res_taken}, 32'd1);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_cnt_branch", {16'b0, cnt_branch}, 32'(exp_br));
        end
        complete(1'b1);

        // Flush while in CMP aborts the request.
        drive(vecs[1]);
        accept();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_cmp_req_ready", {31'b0, req_ready}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("flush_cmp_no_valid", {31'b0, res_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check_counts("flush_cmp");

        // Flush together with a request in IDLE: not accepted.
        drive(vecs[0]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_idle_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("flush_idle_no_valid", {31'b0, res_valid}, 32'd0);

        // Flush together with res_ready in HOLD: flush wins, nothing counted.
        drive(vecs[3]);
        accept();
        wait_valid(lat);
        chk("flush_hold_latency", 32'(lat), 32'd2);
        res_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        flush = 1'b0;
        chk("flush_hold_valid", {31'b0, res_valid}, 32'd0);
        chk("flush_hold_req_ready", {31'b0, req_ready}, 32'd1);
        check_counts("flush_hold");

        // Asynchronous reset while holding a result.
        drive(vecs[0]);
        accept();
        wait_valid(lat);
        #2 rst = 1'b1;
        #1;
        chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_res_taken", {31'b0, res_taken}, 32'd0);
        chk("arst_res_target", res_target, 32'd0);
        exp_br = 0;
        exp_tk = 0;
        check_counts("arst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Four taken results: the 2-bit counters stop at 3.
        for (int i = 0; i < 4; i++) begin
            drive(vecs[9]);
            accept();
            wait_valid(lat);
            chk("sat_latency", 32'(lat), 32'd2);
            complete(1'b1);
        end
        chk("sat_final_cnt2_taken", {30'b0, d2_cnt_taken}, 32'd3);
        chk("sat_final_cnt_taken", {16'b0, cnt_taken}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
